// File: rtl/vga_pkg.sv
// Shared definitions for the display subsystem. The timing generator and the
// frame-buffer arbiter both use these.
//
// Contents:
//   H_DISP_DEF, V_DISP_DEF : default visible raster size (pixels, lines)
//   arb_state_t            : frame-buffer arbiter FSM encoding
package vga_pkg;

  localparam int H_DISP_DEF = 1280;
  localparam int V_DISP_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DRAW  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/line_base.sv
// Start address of a display line in the frame buffer: line_y * 1280, built
// from two shifts and an add ((y << 10) + (y << 8)) so no multiplier is
// inferred. The constant is tied to the 1280-pixel line width.
//
// Ports:
//   line_y : in  [10:0]       line number
//   base   : out [ADDR_W-1:0] word address of pixel 0 of that line
module line_base #(
  parameter int ADDR_W = 21
) (
  input  logic [10:0]       line_y,
  output logic [ADDR_W-1:0] base
);

  assign base = (ADDR_W'(line_y) << 10) + (ADDR_W'(line_y) << 8);

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer memory arbiter. Fetches one display line into the line buffer
// as a stream of pipelined reads, and slips single drawing-engine writes into
// the one-cycle gaps left after every burst of reads.
//
// Ports:
//   clk, rst_n                         : pixel clock, async active-low reset
//   line_req, line_y                   : pulse to fetch line line_y
//   draw_req, draw_addr, draw_wdata    : held write request from the drawing engine
//   draw_ack                           : pulse when that write is accepted
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ready               : memory command channel (valid/ready)
//   mem_rvalid, mem_rdata              : in-order read returns
//   lb_we, lb_addr, lb_wdata           : line-buffer write port
//   fetch_busy                         : line fetch in progress
//   overrun                            : sticky, a line request came while busy
module fb_arbiter
  import vga_pkg::*;
#(
  parameter int H_DISP  = H_DISP_DEF,
  parameter int V_DISP  = V_DISP_DEF,
  parameter int BURST   = 16,
  parameter int MAX_OUT = 8,
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [10:0]       line_y,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [10:0]       lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_busy,
  output logic              overrun
);

  localparam int OUT_W   = $clog2(MAX_OUT + 1);
  localparam int BURST_W = (BURST > 1) ? $clog2(BURST) : 1;

  arb_state_t          state, state_nxt;
  logic [ADDR_W-1:0]   base, base_calc;
  logic [10:0]         issue_cnt, ret_cnt;
  logic [OUT_W-1:0]    outstanding;
  logic [BURST_W-1:0]  burst_cnt;
  logic                gap;
  logic                line_ok, rd_acc, ret;

  line_base #(.ADDR_W(ADDR_W)) u_line_base (
    .line_y (line_y),
    .base   (base_calc)
  );

  assign line_ok = line_req && (line_y < 11'(V_DISP));
  assign rd_acc  = mem_req && mem_ready && !mem_we;
  // Returns are only meaningful while a fetch owns the line buffer; anything
  // arriving in IDLE is a leftover from an aborted fetch.
  assign ret     = mem_rvalid && (state != IDLE);

  assign lb_we    = ret;
  assign lb_addr  = ret ? ret_cnt : '0;
  assign lb_wdata = ret ? mem_rdata : '0;

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    draw_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (line_ok)       state_nxt = FETCH;
        else if (draw_req) state_nxt = DRAW;
      end
      FETCH: begin
        // Reaching the end of the line takes priority over the final gap, so
        // a line of N bursts offers N-1 write slots.
        if (issue_cnt == 11'(H_DISP)) begin
          state_nxt = DRAIN;
        end else if (gap) begin
          if (draw_req) state_nxt = DRAW;
        end else if (outstanding < OUT_W'(MAX_OUT)) begin
          // Address derives only from registered state, so it holds while stalled.
          mem_req  = 1'b1;
          mem_addr = base + ADDR_W'(issue_cnt);
        end
      end
      DRAIN: begin
        if (ret_cnt == 11'(H_DISP)) state_nxt = IDLE;
      end
      DRAW: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = draw_addr;
        mem_wdata = draw_wdata;
        if (mem_ready) begin
          draw_ack  = 1'b1;
          state_nxt = fetch_busy ? FETCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      burst_cnt   <= '0;
      gap         <= 1'b0;
      fetch_busy  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && line_ok) begin
        base        <= base_calc;
        issue_cnt   <= '0;
        ret_cnt     <= '0;
        outstanding <= '0;
        burst_cnt   <= '0;
        gap         <= 1'b0;
        fetch_busy  <= 1'b1;
      end else begin
        if (state == FETCH && gap) gap <= 1'b0;
        if (rd_acc) begin
          issue_cnt <= issue_cnt + 11'd1;
          if (burst_cnt == BURST_W'(BURST - 1)) begin
            burst_cnt <= '0;
            gap       <= 1'b1;
          end else begin
            burst_cnt <= burst_cnt + BURST_W'(1);
          end
        end
        if (ret) ret_cnt <= ret_cnt + 11'd1;
        if (rd_acc && !ret)
          outstanding <= outstanding + OUT_W'(1);
        else if (!rd_acc && ret && outstanding != '0)
          outstanding <= outstanding - OUT_W'(1);
        if (state == DRAIN && ret_cnt == 11'(H_DISP)) fetch_busy <= 1'b0;
      end
      if (line_ok && fetch_busy) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural in-order memory model.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_req;
  logic [10:0] line_y;
  logic        draw_req;
  logic [20:0] draw_addr;
  logic [15:0] draw_wdata;
  logic        draw_ack;
  logic        mem_req, mem_we;
  logic [20:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        lb_we;
  logic [10:0] lb_addr;
  logic [15:0] lb_wdata;
  logic        fetch_busy, overrun;

  always #5 clk = ~clk;

  fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_y(line_y),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_ack(draw_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .lb_we(lb_we),
    .lb_addr(lb_addr), .lb_wdata(lb_wdata), .fetch_busy(fetch_busy),
    .overrun(overrun)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;
  rd_t rq[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  bit rnd_ready = 1'b0;
  int lat = 3;
  int draw_target = 0;
  bit spacing_on = 1'b0;
  logic [20:0] exp_base = '0;

  int n_acc, n_wr, n_ack, n_lb, n_req, addr_errs, lb_errs, stall_errs, ack_errs;
  int max_q, last_lb, reads_since_ack;
  logic [20:0] first_addr, last_addr, p_addr;
  logic [15:0] p_wd;
  logic p_we;
  bit prev_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_acc = 0; n_wr = 0; n_ack = 0; n_lb = 0; n_req = 0;
    addr_errs = 0; lb_errs = 0; stall_errs = 0; ack_errs = 0;
    max_q = 0; last_lb = 0; reads_since_ack = 0;
    first_addr = '0; last_addr = '0; prev_stall = 1'b0;
    draw_target = 0; spacing_on = 1'b0;
  endtask

  // One clock cycle: drive inputs on the falling edge, observe 1 ns later.
  task automatic cyc(input bit lr, input logic [10:0] ly);
    @(negedge clk);
    ncyc++;
    line_req = lr;
    line_y   = ly;
    if (rq.size() > 0 && rq[0].due <= ncyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rq[0].data;
      rq.delete(0);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    mem_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    draw_req   = (n_ack < draw_target);
    draw_addr  = 21'h1F0000 + 21'(n_ack);
    draw_wdata = 16'hC000 + 16'(n_ack);
    #1;
    if (prev_stall && !(mem_req === 1'b1 && mem_addr === p_addr &&
                        mem_we === p_we && mem_wdata === p_wd))
      stall_errs++;
    prev_stall = mem_req && !mem_ready;
    p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
    if (mem_req) n_req++;
    if (draw_ack && !(mem_req && mem_ready && mem_we)) ack_errs++;
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        n_wr++;
        if (!draw_ack || mem_addr !== draw_addr || mem_wdata !== draw_wdata) ack_errs++;
        if (spacing_on && reads_since_ack != 16) ack_errs++;
        reads_since_ack = 0;
      end else begin
        if (n_acc == 0) first_addr = mem_addr;
        last_addr = mem_addr;
        if (mem_addr !== exp_base + 21'(n_acc)) addr_errs++;
        rq.push_back(rd_t'{due: ncyc + lat, data: mem_addr[15:0] ^ 16'h5A5A});
        n_acc++;
        reads_since_ack++;
        if (rq.size() > max_q) max_q = rq.size();
      end
    end
    if (draw_ack) n_ack++;
    if (lb_we) begin
      if (lb_addr !== 11'(n_lb) ||
          lb_wdata !== ((exp_base[15:0] + 16'(n_lb)) ^ 16'h5A5A))
        lb_errs++;
      n_lb++;
      last_lb = ncyc;
    end
  endtask

  task automatic run_fetch(input logic [10:0] ly, input int ovr_at);
    int busy_fall;
    exp_base = 21'(ly) * 21'd1280;
    cyc(1'b1, ly);
    cyc(1'b0, '0);
    check("busy_rise", fetch_busy, 1);
    busy_fall = -1;
    for (int i = 0; i < 20000 && busy_fall < 0; i++) begin
      cyc(i == ovr_at, 11'd7);
      if (!fetch_busy) busy_fall = ncyc;
    end
    check("fetch_done", busy_fall >= 0, 1);
    check("read_count", n_acc, 1280);
    check("read_addr_errs", addr_errs, 0);
    check("lb_count", n_lb, 1280);
    check("lb_errs", lb_errs, 0);
    check("outstanding_le_8", max_q <= 8, 1);
    check("busy_fall_delay", busy_fall - last_lb, 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rq.delete();
    line_req = 1'b0; draw_req = 1'b0; mem_ready = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_lb_we", lb_we, 0);
    check("rst_lb_addr", lb_addr, 0);
    check("rst_lb_wdata", lb_wdata, 0);
    check("rst_draw_ack", draw_ack, 0);
    check("rst_fetch_busy", fetch_busy, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; line_req = 1'b0; line_y = '0; draw_req = 1'b0;
    draw_addr = '0; draw_wdata = '0; mem_ready = 1'b1; mem_rvalid = 1'b0;
    mem_rdata = '0;
    clear_stats();
    do_reset();

    // Line 0, latency 3, always ready.
    lat = 3; rnd_ready = 1'b0; clear_stats();
    run_fetch(11'd0, -1);
    check("l0_first_addr", first_addr, 0);
    check("l0_last_addr", last_addr, 1279);
    check("l0_overrun", overrun, 0);

    // Out-of-range line in IDLE: nothing happens.
    clear_stats();
    cyc(1'b1, 11'd1024);
    for (int i = 0; i < 20; i++) cyc(1'b0, '0);
    check("bad_line_no_req", n_req, 0);
    check("bad_line_busy", fetch_busy, 0);
    check("bad_line_overrun0", overrun, 0);

    // Single write from IDLE, returns to IDLE.
    clear_stats(); draw_target = 1;
    for (int i = 0; i < 6; i++) cyc(1'b0, '0);
    check("idle_draw_acks", n_ack, 1);
    check("idle_draw_writes", n_wr, 1);
    check("idle_draw_reads", n_acc, 0);
    check("idle_draw_ack_errs", ack_errs, 0);

    // Last line, latency 10: outstanding saturates at 8.
    lat = 10; clear_stats();
    run_fetch(11'd1023, -1);
    check("l1023_first_addr", first_addr, 1309440);
    check("l1023_last_addr", last_addr, 1310719);
    check("l1023_max_out", max_q, 8);

    // Draw held throughout (including the line_req cycle, which wins).
    lat = 3; clear_stats(); draw_target = 79; spacing_on = 1'b1;
    run_fetch(11'd5, -1);
    check("draw_acks", n_ack, 79);
    check("draw_writes", n_wr, 79);
    check("draw_gap_errs", ack_errs, 0);

    // Random ready with latency 10.
    lat = 10; rnd_ready = 1'b1; clear_stats();
    run_fetch(11'd100, -1);
    check("rnd_stall_errs", stall_errs, 0);
    rnd_ready = 1'b0;

    // Overrun: second request mid-fetch is ignored, fetch completes.
    lat = 3; clear_stats();
    run_fetch(11'd9, 200);
    check("overrun_set", overrun, 1);
    clear_stats();
    cyc(1'b1, 11'd1024);
    for (int i = 0; i < 20; i++) cyc(1'b0, '0);
    check("bad_line2_no_req", n_req, 0);
    check("bad_line2_overrun1", overrun, 1);

    // Reset mid-fetch, then stale returns, then a normal fetch.
    lat = 10; clear_stats(); exp_base = 21'd3 * 21'd1280;
    cyc(1'b1, 11'd3);
    for (int i = 0; i < 100; i++) cyc(1'b0, '0);
    check("mid_fetch_busy", fetch_busy, 1);
    do_reset();
    clear_stats();
    rq.push_back(rd_t'{due: ncyc + 2, data: 16'h1111});
    rq.push_back(rd_t'{due: ncyc + 3, data: 16'h2222});
    for (int i = 0; i < 6; i++) cyc(1'b0, '0);
    check("stale_lb_we", n_lb, 0);
    check("stale_no_req", n_req, 0);
    lat = 3; clear_stats();
    run_fetch(11'd2, -1);
    check("post_rst_first_addr", first_addr, 2560);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
